// File: rtl/tx_fifo_burst_arbiter.sv
// rtl/tx_fifo_burst_arbiter.sv - round-robin burst arbiter draining N_CH show-ahead TX FIFOs into one stream
// One grant moves up to BURST_LEN words from one channel; a mid-burst underrun of STALL_TO cycles truncates it.
module tx_fifo_burst_arbiter #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int STALL_TO  = 8,
  parameter int CH_W      = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arb_en,
  input  logic [N_CH*DATA_W-1:0] ch_rd_data,
  input  logic [N_CH-1:0]        ch_rd_vld,
  output logic [N_CH-1:0]        ch_rd_en,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   trunc,
  output logic                   busy
);

  localparam int BC_W = $clog2(BURST_LEN);
  localparam int SC_W = $clog2(STALL_TO + 1);
  localparam logic [BC_W-1:0] BEAT_LAST  = BC_W'(BURST_LEN - 1);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_TO - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(N_CH - 1);

  typedef enum logic {ARB, XFER} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0] ch_word [N_CH];
  logic [CH_W-1:0]   rr_idx;
  logic [CH_W-1:0]   pick;
  logic              pick_vld;
  logic              gnt_vld;
  logic              beat;

  for (genvar g = 0; g < N_CH; g++) begin : g_word
    assign ch_word[g] = ch_rd_data[g*DATA_W +: DATA_W];
  end

  // Scan downward so the last hit is the nearest requester after last_q.
  always_comb begin : rr_pick
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int i = N_CH; i >= 1; i--) begin
      rr_idx = CH_W'((int'(last_q) + i) % N_CH);
      if (ch_rd_vld[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin : datapath
    busy     = (state_q == XFER);
    gnt_vld  = ch_rd_vld[gnt_q];
    out_vld  = busy & gnt_vld;
    beat     = out_vld & out_rdy;
    out_data = busy ? ch_word[gnt_q] : '0;
    out_ch   = busy ? gnt_q : '0;
    out_sof  = out_vld & (beat_cnt_q == '0);
    out_eof  = out_vld & (beat_cnt_q == BEAT_LAST);
    trunc    = busy & ~gnt_vld & (stall_cnt_q == STALL_LAST);
    ch_rd_en = '0;
    if (beat) begin
      ch_rd_en[gnt_q] = 1'b1;
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ARB: begin
        if (arb_en && pick_vld) begin
          state_d     = XFER;
          gnt_d       = pick;
          last_d      = pick;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
        end
      end
      XFER: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        // Back-pressure keeps gnt_vld high, so only a FIFO underrun counts as a stall.
        if (gnt_vld) begin
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((beat && (beat_cnt_q == BEAT_LAST)) || trunc) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      gnt_q       <= '0;
      last_q      <= CH_LAST;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/tx_fifo_burst_arbiter.md
Name: tx_fifo_burst_arbiter

Overview:
- Round-robin burst arbiter that drains N_CH prefetch TX FIFOs, which expose the rd_data/rd_vld/rd_en show-ahead read interface, into one shared output stream.
- Each grant moves one burst of up to BURST_LEN words from one channel.
- The output carries a channel tag plus start/end-of-burst markers.
- It sits between the per-source TX FIFOs and the single downstream packetiser/transmitter, and replaces ad-hoc muxing of FIFO read ports.

Parameters:
N_CH, 4, number of FIFO channels (2..8)
DATA_W, 32, data width per channel (equals FIFO c_RD_DATA_WIDTH)
BURST_LEN, 16, maximum words per grant (2..256)
STALL_TO, 8, consecutive mid-burst cycles with ch_rd_vld low before the burst is truncated (1..255)
CH_W, 2, width of the channel index, = clog2(N_CH)

Ports:
clk  in  1  single clock; all FIFOs read on this clock
rst  in  1  asynchronous, active-high reset
arb_en  in  1  1 = new grants allowed; 0 = finish current burst then hold
ch_rd_data  in  N_CH*DATA_W  FIFO read data; channel i occupies bits [i*DATA_W +: DATA_W]
ch_rd_vld  in  N_CH  FIFO rd_vld (head word valid)
ch_rd_en  out  N_CH  FIFO rd_en (pop)
out_data  out  DATA_W  data of the granted channel
out_vld  out  1  output word valid
out_rdy  in  1  downstream ready
out_ch  out  CH_W  channel index of out_data
out_sof  out  1  first word of a burst (qualified by out_vld)
out_eof  out  1  BURST_LEN-th word of a burst (qualified by out_vld)
trunc  out  1  one-cycle pulse when a burst is ended by stall timeout
busy  out  1  1 while in XFER

Behaviour:
- Reset values:
  - state = ARB; gnt = 0.
  - Last-served pointer = N_CH-1, so channel 0 has first priority.
  - beat_cnt = 0; stall_cnt = 0.
  - ch_rd_en = 0; out_vld = 0; out_sof = 0; out_eof = 0; trunc = 0; busy = 0; out_ch = 0.
- FSM has two states, ARB and XFER.
- ARB:
  - If arb_en=1 and any ch_rd_vld=1, the first requesting channel searched upward from (last+1) mod N_CH is registered into gnt.
  - That same edge sets last := gnt, beat_cnt := 0, stall_cnt := 0 and moves to XFER.
  - Otherwise the FSM stays in ARB.
  - Outputs are idle in ARB, giving a 1-cycle bubble between bursts.
- XFER datapath, combinational pass-through with zero latency:
  - out_data = ch_rd_data[gnt]; out_ch = gnt.
  - out_vld = ch_rd_vld[gnt].
  - ch_rd_en[gnt] = out_vld & out_rdy; all other ch_rd_en = 0.
  - A beat is out_vld & out_rdy.
- XFER markers:
  - out_sof = out_vld & (beat_cnt==0).
  - out_eof = out_vld & (beat_cnt==BURST_LEN-1).
- On each beat, beat_cnt increments.
  - A beat with beat_cnt==BURST_LEN-1 ends the burst, and the next state is ARB.
- Stall timeout:
  - stall_cnt increments on cycles where ch_rd_vld[gnt]=0 and clears when it is 1.
  - Downstream back-pressure (out_vld=1, out_rdy=0) is not a stall and never times out.
  - If stall_cnt reaches STALL_TO-1 while vld is still 0, trunc pulses for 1 cycle and the next state is ARB.
  - On truncation the burst has no eof; the downstream uses trunc to close it.
  - A truncation with beat_cnt==0 (no words sent) still pulses trunc.
- arb_en=0 during XFER does not cut the burst; it only blocks the next grant.
- Round-robin is strict: with all channels requesting and full bursts, grants go 0,1,2,3,0,...
  - A single requester is re-granted after the 1-cycle ARB bubble.
- The FIFO show-ahead guarantee is required: out_data stays stable while out_vld=1 and out_rdy=0.
- Words are never popped while out_rdy=0.
- The block does not generate or hold data; it stores no data words.
- Async rst mid-burst: all state clears immediately, and ch_rd_en drops the same cycle.
  - A partial burst is abandoned; any word already popped was already accepted downstream.
- Peak throughput is BURST_LEN words per BURST_LEN+1 cycles.

Test Plan:
- Reset, then ch_rd_vld=4'b0001, out_rdy=1, BURST_LEN=16 -> gnt=0 one cycle after vld; 16 consecutive beats with sof on beat 0 and eof on beat 15; 1 idle cycle; then re-grant to ch0.
- All four vld held 1, out_rdy=1 -> bursts in order 0,1,2,3,0; out_ch matches; each burst exactly 16 words; no trunc.
- Mid-burst on ch2, drop ch_rd_vld[2] after 5 words for 8 cycles (STALL_TO=8) -> trunc pulses once; no eof; next grant goes to ch3. Repeat with a 7-cycle gap -> burst resumes and completes with eof at word 16, no trunc.
- out_rdy toggled 1,0,0,1 per cycle during a burst -> ch_rd_en only on out_rdy=1 cycles; out_data held across stalls; exactly 16 pops; no trunc.
- arb_en cleared at word 3 of a ch1 burst -> burst completes with eof; FSM stays in ARB with outputs idle; arb_en=1 -> next grant goes to ch2.
- Assert rst at word 9 of a burst -> ch_rd_en/out_vld go 0 immediately; after release, first grant goes to ch0, sof on its first beat.
